// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR frame arbiter: command codes, FSM states, width helper.
package ddr_pkg;
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/frame_addr_gen.sv
// Maps a frame slot and burst offset to a DDR byte address.
module frame_addr_gen
  import ddr_pkg::*;
#(
  parameter int ADDR_WIDTH   = 28,
  parameter int FRAME_BURSTS = 4800,
  parameter int BURST_INC    = 8,
  parameter int SLOT_W       = 3,
  parameter int OFF_W        = 13
) (
  input  logic [SLOT_W-1:0]     slot,
  input  logic [OFF_W-1:0]      off,
  output logic [ADDR_WIDTH-1:0] addr
);
  localparam logic [ADDR_WIDTH-1:0] FB_A = ADDR_WIDTH'(FRAME_BURSTS);
  localparam logic [ADDR_WIDTH-1:0] BI_A = ADDR_WIDTH'(BURST_INC);

  assign addr = (ADDR_WIDTH'(slot) * FB_A + ADDR_WIDTH'(off)) * BI_A;
endmodule

// File: rtl/ddr_frame_arbiter.sv
// Shares the DDR app-command port between the frame writer and the multi-frame reader,
// meters reads with credits and tags returned read bursts with their source frame.
module ddr_frame_arbiter
  import ddr_pkg::*;
#(
  parameter int ADDR_WIDTH      = 28,
  parameter int NUM_FRAMES      = 4,
  parameter int FRAME_BURSTS    = 4800,
  parameter int BURST_INC       = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          freeze,
  input  logic                          wr_req,
  output logic                          wr_ack,
  input  logic                          rd_req,
  output logic                          rd_ack,
  input  logic                          rd_credit_ret,
  input  logic                          app_rdy,
  input  logic                          app_wdf_rdy,
  output logic                          app_en,
  output logic                          app_wdf_wren,
  output logic [2:0]                    app_cmd,
  output logic [ADDR_WIDTH-1:0]         app_addr,
  input  logic                          mem_rd_valid,
  output logic                          rd_out_valid,
  output logic [clog2(NUM_FRAMES)-1:0]  rd_frame_sel,
  output logic                          frame_done
);
  localparam int SLOT_W = clog2(NUM_FRAMES + 1);
  localparam int OFF_W  = clog2(FRAME_BURSTS);
  localparam int K_W    = clog2(NUM_FRAMES);
  localparam int SEL_W  = clog2(NUM_FRAMES);
  localparam int CR_W   = clog2(MAX_OUTSTANDING + 1);
  localparam longint SPAN = longint'(NUM_FRAMES + 1) * longint'(FRAME_BURSTS) * longint'(BURST_INC);

  if (SPAN > (longint'(1) << ADDR_WIDTH) || MAX_OUTSTANDING < NUM_FRAMES) begin : g_param_chk
    $error("ddr_frame_arbiter: frame ring exceeds address space or too few credits");
  end

  state_t            state, last_grant;
  logic [SLOT_W-1:0] wr_slot, frames_valid, ag_slot;
  logic [OFF_W-1:0]  wr_off, rd_off, ag_off;
  logic [K_W-1:0]    k;
  logic [SEL_W-1:0]  ret_cnt;
  logic [CR_W-1:0]   credits, credits_nxt;
  logic [CR_W:0]     cr_sum;
  logic [ADDR_WIDTH-1:0] ag_addr;
  logic              wr_ok, rd_ok, pick_wr, rd_acc, use_rd;
  int                rd_k, rd_slot;

  assign wr_ok   = wr_req && !freeze;
  assign rd_ok   = rd_req && (frames_valid == SLOT_W'(NUM_FRAMES)) && (credits >= CR_W'(NUM_FRAMES));
  assign pick_wr = wr_ok && (!rd_ok || last_grant == RD);
  assign rd_acc  = (state == RD) && app_rdy;

  // One address generator: in IDLE it prepares the command about to be granted,
  // in RD it prepares the next frame of the group.
  always_comb begin
    rd_k    = (state == RD) ? int'(k) + 1 : 0;
    rd_slot = int'(wr_slot) + NUM_FRAMES - rd_k;
    if (rd_slot >= NUM_FRAMES + 1) rd_slot = rd_slot - (NUM_FRAMES + 1);
    use_rd  = (state == RD) || (state == IDLE && !pick_wr);
    ag_slot = use_rd ? SLOT_W'(rd_slot) : wr_slot;
    ag_off  = use_rd ? rd_off : wr_off;
  end

  frame_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .FRAME_BURSTS(FRAME_BURSTS), .BURST_INC(BURST_INC),
    .SLOT_W(SLOT_W), .OFF_W(OFF_W)
  ) u_addr (
    .slot(ag_slot),
    .off (ag_off),
    .addr(ag_addr)
  );

  // Returns beyond the cap are dropped; accept and return in one cycle cancel.
  always_comb begin
    cr_sum = {1'b0, credits} + (CR_W+1)'(rd_credit_ret) - (CR_W+1)'(rd_acc);
    credits_nxt = (cr_sum > (CR_W+1)'(MAX_OUTSTANDING)) ? CR_W'(MAX_OUTSTANDING) : cr_sum[CR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= RD;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_cmd      <= CMD_WRITE;
      app_addr     <= '0;
      wr_ack       <= 1'b0;
      rd_ack       <= 1'b0;
      frame_done   <= 1'b0;
      rd_out_valid <= 1'b0;
      rd_frame_sel <= '0;
      ret_cnt      <= '0;
      wr_slot      <= '0;
      wr_off       <= '0;
      rd_off       <= '0;
      frames_valid <= '0;
      k            <= '0;
      credits      <= CR_W'(MAX_OUTSTANDING);
    end else begin
      wr_ack       <= 1'b0;
      rd_ack       <= 1'b0;
      frame_done   <= 1'b0;
      credits      <= credits_nxt;
      rd_out_valid <= mem_rd_valid;
      if (mem_rd_valid) begin
        rd_frame_sel <= ret_cnt;
        ret_cnt      <= (ret_cnt == SEL_W'(NUM_FRAMES - 1)) ? '0 : ret_cnt + SEL_W'(1);
      end
      case (state)
        IDLE: if (wr_ok || rd_ok) begin
          app_en   <= 1'b1;
          app_addr <= ag_addr;
          k        <= '0;
          if (pick_wr) begin
            state        <= WR;
            last_grant   <= WR;
            app_cmd      <= CMD_WRITE;
            app_wdf_wren <= 1'b1;
          end else begin
            state      <= RD;
            last_grant <= RD;
            app_cmd    <= CMD_READ;
          end
        end
        WR: if (app_rdy && app_wdf_rdy) begin
          app_en       <= 1'b0;
          app_wdf_wren <= 1'b0;
          wr_ack       <= 1'b1;
          state        <= IDLE;
          if (wr_off == OFF_W'(FRAME_BURSTS - 1)) begin
            wr_off     <= '0;
            wr_slot    <= (wr_slot == SLOT_W'(NUM_FRAMES)) ? '0 : wr_slot + SLOT_W'(1);
            if (frames_valid != SLOT_W'(NUM_FRAMES)) frames_valid <= frames_valid + SLOT_W'(1);
            frame_done <= 1'b1;
            rd_off     <= '0;
          end else begin
            wr_off <= wr_off + OFF_W'(1);
          end
        end
        RD: if (app_rdy) begin
          if (k == K_W'(NUM_FRAMES - 1)) begin
            app_en <= 1'b0;
            rd_ack <= 1'b1;
            state  <= IDLE;
            rd_off <= (rd_off == OFF_W'(FRAME_BURSTS - 1)) ? '0 : rd_off + OFF_W'(1);
          end else begin
            k        <= k + K_W'(1);
            app_addr <= ag_addr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// Directed + randomized bench for ddr_frame_arbiter against a transaction-level ring model.
module tb_ddr_frame_arbiter;
  localparam int AW = 16, NF = 2, FB = 4, BI = 8, MO = 4;

  logic clk = 1'b0, rst_n, freeze, wr_req, rd_req, rd_credit_ret, app_rdy, app_wdf_rdy, mem_rd_valid;
  logic wr_ack, rd_ack, app_en, app_wdf_wren, rd_out_valid, frame_done;
  logic [2:0] app_cmd;
  logic [AW-1:0] app_addr;
  logic [0:0] rd_frame_sel;

  always #5 clk = ~clk;

  ddr_frame_arbiter #(
    .ADDR_WIDTH(AW), .NUM_FRAMES(NF), .FRAME_BURSTS(FB), .BURST_INC(BI), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .wr_req(wr_req), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_credit_ret(rd_credit_ret), .app_rdy(app_rdy),
    .app_wdf_rdy(app_wdf_rdy), .app_en(app_en), .app_wdf_wren(app_wdf_wren), .app_cmd(app_cmd),
    .app_addr(app_addr), .mem_rd_valid(mem_rd_valid), .rd_out_valid(rd_out_valid),
    .rd_frame_sel(rd_frame_sel), .frame_done(frame_done)
  );

  int checks = 0, errors = 0;
  // Model: total bursts written, reader offset, group progress, credits, last winner, return count.
  int n_w, rd_off_m, rd_k_m, credits_m, ret_m, busy, cnt_w, cnt_r, cnt_fd;
  bit last_wr;
  int acc_q[$];
  int grant_q[$];
  int sel_q[$];
  logic [AW-1:0] a0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fv_m();
    return (n_w / FB < NF) ? n_w / FB : NF;
  endfunction

  function automatic int wr_addr_m();
    return (((n_w / FB) % (NF + 1)) * FB + n_w % FB) * BI;
  endfunction

  function automatic int rd_addr_m(input int kk);
    int slot;
    slot = ((n_w / FB) % (NF + 1) - 1 - kk + 2 * (NF + 1)) % (NF + 1);
    return (slot * FB + rd_off_m) * BI;
  endfunction

  task automatic model_reset();
    n_w = 0; rd_off_m = 0; rd_k_m = 0; credits_m = MO; ret_m = 0; busy = 0; last_wr = 1'b0;
  endtask

  // One clock: predict from inputs held across the edge, then compare after it.
  task automatic step();
    bit rq, aw, ar, gw, gr, fw, rdk, wok, rok;
    int c;
    rq = rst_n;
    aw = (busy == 1) && app_rdy && app_wdf_rdy;
    ar = (busy == 2) && app_rdy;
    if (rq && (aw || ar)) acc_q.push_back(int'(app_addr));
    gw = 1'b0; gr = 1'b0;
    if (busy == 0) begin
      wok = wr_req && !freeze;
      rok = rd_req && fv_m() == NF && credits_m >= NF;
      if (wok && (!rok || !last_wr)) gw = 1'b1;
      else if (rok) gr = 1'b1;
    end
    @(posedge clk); #1;
    if (!rq) begin
      model_reset();
      chk("rst_app_en", app_en, 0);        chk("rst_wdf_wren", app_wdf_wren, 0);
      chk("rst_wr_ack", wr_ack, 0);        chk("rst_rd_ack", rd_ack, 0);
      chk("rst_rd_out_valid", rd_out_valid, 0); chk("rst_frame_done", frame_done, 0);
      chk("rst_app_cmd", app_cmd, 0);      chk("rst_app_addr", app_addr, 0);
      chk("rst_rd_frame_sel", rd_frame_sel, 0);
      return;
    end
    c = credits_m - int'(ar) + int'(rd_credit_ret);
    credits_m = (c > MO) ? MO : c;
    fw = 1'b0; rdk = 1'b0;
    if (aw) begin
      n_w++; busy = 0;
      if (n_w % FB == 0) begin fw = 1'b1; rd_off_m = 0; end
    end
    if (ar) begin
      rd_k_m++;
      if (rd_k_m == NF) begin rd_k_m = 0; rd_off_m = (rd_off_m + 1) % FB; busy = 0; rdk = 1'b1; end
    end
    if (gw) begin busy = 1; last_wr = 1'b1; grant_q.push_back(1); end
    if (gr) begin busy = 2; last_wr = 1'b0; rd_k_m = 0; grant_q.push_back(2); end
    chk("wr_ack", wr_ack, aw);
    chk("rd_ack", rd_ack, rdk);
    chk("frame_done", frame_done, fw);
    chk("rd_out_valid", rd_out_valid, mem_rd_valid);
    if (mem_rd_valid) begin
      chk("rd_frame_sel", rd_frame_sel, ret_m);
      sel_q.push_back(int'(rd_frame_sel));
      ret_m = (ret_m + 1) % NF;
    end
    chk("app_en", app_en, busy != 0);
    chk("app_wdf_wren", app_wdf_wren, busy == 1);
    if (busy == 1) begin chk("wr_cmd", app_cmd, 0); chk("wr_addr", app_addr, wr_addr_m()); end
    if (busy == 2) begin chk("rd_cmd", app_cmd, 1); chk("rd_addr", app_addr, rd_addr_m(rd_k_m)); end
    cnt_w += int'(aw); cnt_r += int'(rdk); cnt_fd += int'(fw);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    rst_n = 1'b0; freeze = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rd_credit_ret = 1'b0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; mem_rd_valid = 1'b0;
    cnt_w = 0; cnt_r = 0; cnt_fd = 0;
    model_reset();
    step(); step();
    rst_n = 1'b1;
    step();

    // Write one frame.
    acc_q.delete(); grant_q.delete();
    wr_req = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    for (int i = 0; i < 40 && cnt_w < 4; i++) step();
    wr_req = 1'b0;
    chk("t1_addr0", qget(acc_q, 0), 0);  chk("t1_addr1", qget(acc_q, 1), 8);
    chk("t1_addr2", qget(acc_q, 2), 16); chk("t1_addr3", qget(acc_q, 3), 24);
    chk("t1_frame_done_cnt", cnt_fd, 1);
    chk("t1_wr_slot", dut.wr_slot, 1);

    // Second frame with rd_req asserted (gated), then one read group.
    acc_q.delete(); grant_q.delete();
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 40 && cnt_w < 8; i++) step();
    wr_req = 1'b0;
    for (int i = 0; i < 40 && cnt_r < 1; i++) step();
    rd_req = 1'b0;
    step(); step();
    for (int i = 0; i < 4; i++) chk("t2_gated_grant", qget(grant_q, i), 1);
    chk("t2_rd_addr_k0", qget(acc_q, 4), 32);
    chk("t2_rd_addr_k1", qget(acc_q, 5), 0);
    chk("t2_rd_ack_cnt", cnt_r, 1);

    // Contention: strict alternation.
    grant_q.delete();
    wr_req = 1'b1; rd_req = 1'b1; rd_credit_ret = 1'b1;
    for (int i = 0; i < 60 && grant_q.size() < 4; i++) step();
    wr_req = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < 20 && busy != 0; i++) step();
    for (int i = 0; i < 4; i++) step();
    rd_credit_ret = 1'b0;
    chk("t3_g0", qget(grant_q, 0), 1); chk("t3_g1", qget(grant_q, 1), 2);
    chk("t3_g2", qget(grant_q, 2), 1); chk("t3_g3", qget(grant_q, 3), 2);
    chk("t3_credits_full", dut.credits, MO);

    // Credits exhaust after two groups.
    begin
      int base;
      base = cnt_r;
      rd_req = 1'b1;
      for (int i = 0; i < 40 && cnt_r < base + 2; i++) step();
    end
    chk("t4_credits_zero", dut.credits, 0);
    for (int i = 0; i < 5; i++) step();
    chk("t4_blocked", app_en, 0);
    rd_credit_ret = 1'b1; step(); rd_credit_ret = 1'b0; step();
    chk("t4_blocked_one_credit", app_en, 0);
    rd_credit_ret = 1'b1; step(); rd_credit_ret = 1'b0; step();
    chk("t4_granted", app_en, 1);
    rd_credit_ret = 1'b1; step();
    chk("t4_accept_and_return", dut.credits, 2);
    rd_credit_ret = 1'b0; rd_req = 1'b0; step();
    chk("t4_group_done_credits", dut.credits, 1);
    step();

    // Backpressure on write data, freeze during and after.
    wr_req = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b0;
    for (int i = 0; i < 10 && app_en !== 1'b1; i++) step();
    freeze = 1'b1;
    a0 = app_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_en_held", app_en, 1); chk("t5_addr_stable", app_addr, a0); chk("t5_no_ack", wr_ack, 0);
    end
    app_wdf_rdy = 1'b1; step();
    chk("t5_ack_under_freeze", wr_ack, 1);
    for (int i = 0; i < 3; i++) begin step(); chk("t5_freeze_blocks", app_en, 0); end
    freeze = 1'b0; wr_req = 1'b0; step();

    // Reset in the middle of a read group, then tagged returns.
    rd_credit_ret = 1'b1; step(); step(); step(); rd_credit_ret = 1'b0;
    rd_req = 1'b1; app_rdy = 1'b0;
    for (int i = 0; i < 10 && app_en !== 1'b1; i++) step();
    rd_req = 1'b0; app_rdy = 1'b1; step();
    app_rdy = 1'b0; rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    chk("t6_idle", app_en, 0); chk("t6_no_rd_ack", rd_ack, 0); chk("t6_credits", dut.credits, MO);
    sel_q.delete();
    mem_rd_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    mem_rd_valid = 1'b0;
    chk("t6_sel0", qget(sel_q, 0), 0); chk("t6_sel1", qget(sel_q, 1), 1);
    chk("t6_sel2", qget(sel_q, 2), 0); chk("t6_sel3", qget(sel_q, 3), 1);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      wr_req        = ($urandom % 4) != 0;
      rd_req        = ($urandom % 2) != 0;
      freeze        = ($urandom % 8) == 0;
      app_rdy       = ($urandom % 4) != 0;
      app_wdf_rdy   = ($urandom % 4) != 0;
      rd_credit_ret = ($urandom % 3) == 0;
      mem_rd_valid  = ($urandom % 3) == 0;
      rst_n         = ($urandom % 600) != 0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
